// File: rtl/mem_access_unit.sv
// Load/store initiator for the unified memory data port: one request at a time,
// byte/half extraction with sign/zero extension, read-modify-write for SB/SH.
`ifndef LDST_WID
`define LDST_WID 4
`define LW_OP  4'd1
`define LH_OP  4'd2
`define LHU_OP 4'd3
`define LB_OP  4'd4
`define LBU_OP 4'd5
`define SW_OP  4'd6
`define SH_OP  4'd7
`define SB_OP  4'd8
`endif

module mem_access_unit #(
  parameter int RD_LAT  = 1,
  parameter int WR_HOLD = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,  // active low
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [`LDST_WID-1:0] req_op_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 resp_valid_o,
  output logic [31:0]          resp_data_o,
  output logic                 resp_misalign_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic                 mem_we_o,
  input  logic [31:0]          mem_rdata_i
);
  localparam int CNT_MAX = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [`LDST_WID-1:0] op_q, op_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_data_q, resp_data_d;
  logic                 resp_mis_q, resp_mis_d;

  function automatic logic is_known(input logic [`LDST_WID-1:0] op);
    return (op >= `LW_OP) && (op <= `SB_OP);
  endfunction

  function automatic logic is_load(input logic [`LDST_WID-1:0] op);
    return (op >= `LW_OP) && (op <= `LBU_OP);
  endfunction

  function automatic logic is_misaligned(input logic [`LDST_WID-1:0] op, input logic [1:0] lo);
    case (op)
      `LW_OP, `SW_OP:           return lo != 2'b00;
      `LH_OP, `LHU_OP, `SH_OP:  return lo[0];
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [`LDST_WID-1:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? w[31:16] : w[15:0];
    b = w[{lo, 3'b000} +: 8];
    case (op)
      `LW_OP:  return w;
      `LH_OP:  return {{16{h[15]}}, h};
      `LHU_OP: return {16'h0000, h};
      `LB_OP:  return {{24{b[7]}}, b};
      `LBU_OP: return {24'h000000, b};
      default: return '0;
    endcase
  endfunction

  // Only the addressed lane takes store data; the rest of the word is preserved.
  function automatic logic [31:0] merge(input logic [`LDST_WID-1:0] op, input logic [1:0] lo,
                                        input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    if (op == `SB_OP) m[{lo, 3'b000} +: 8]       = wd[7:0];
    else              m[{lo[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_mis_d   = resp_mis_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        op_d    = req_op_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        if (!is_known(req_op_i) || is_misaligned(req_op_i, req_addr_i[1:0])) begin
          state_d = RESP;
        end else if (req_op_i == `SW_OP) begin
          state_d     = WR;
          cnt_d       = CW'(WR_HOLD - 1);
          mem_wdata_d = req_wdata_i;
          mem_we_d    = 1'b1;
        end else begin
          state_d = RD;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      RD: if (cnt_q == '0) begin
        rdata_d = mem_rdata_i;
        if (is_load(op_q)) begin
          state_d = RESP;
        end else begin
          mem_wdata_d = merge(op_q, addr_q[1:0], mem_rdata_i, wdata_q);
          mem_we_d    = 1'b1;
          cnt_d       = CW'(WR_HOLD - 1);
          state_d     = WR;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      WR: if (cnt_q == '0) begin
        mem_we_d = 1'b0;
        state_d  = RESP;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      RESP: begin
        // Result is formed on the way out so resp_* only change with resp_valid.
        resp_valid_d = 1'b1;
        resp_mis_d   = is_misaligned(op_q, addr_q[1:0]);
        resp_data_d  = (is_load(op_q) && !resp_mis_d) ? load_ext(op_q, addr_q[1:0], rdata_q) : '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_mis_q   <= resp_mis_d;
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign resp_misalign_o = resp_mis_q;
  assign mem_addr_o      = {addr_q[31:2], 2'b00};
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_we_o        = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a word-array reference model.
`ifndef LDST_WID
`define LDST_WID 4
`define LW_OP  4'd1
`define LH_OP  4'd2
`define LHU_OP 4'd3
`define LB_OP  4'd4
`define LBU_OP 4'd5
`define SW_OP  4'd6
`define SH_OP  4'd7
`define SB_OP  4'd8
`endif

module tb_mem_access_unit;
  localparam int RD_LAT  = 1;
  localparam int WR_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign, mem_we;
  logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // Memory: combinational read, a write commits only after WR_HOLD consecutive we cycles.
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;
  int          we_run;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_run <= 0;
    else if (mem_we) begin
      if (we_run == WR_HOLD - 1) mem[mem_addr[9:2]] <= mem_wdata;
      we_run <= we_run + 1;
    end else we_run <= 0;
    if (pre_we) mem[pre_idx] <= pre_val;
  end

  mem_access_unit #(.RD_LAT(RD_LAT), .WR_HOLD(WR_HOLD)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_misalign_o(resp_misalign),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
  );

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_idx = idx; pre_val = val; pre_we = 1'b1; ref_mem[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference: what the unit should do, from the ISA-level meaning of each op.
  function automatic void model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] data, output logic mis, output int lat,
                                output int wec, output logic [31:0] neww);
    logic [31:0] old, mask, b, h;
    int sh;
    old = ref_mem[addr[9:2]];
    sh = 8 * int'(addr % 4);
    b = (old >> sh) & 32'hFF;
    h = (old >> sh) & 32'hFFFF;
    data = 0; mis = 0; lat = 1; wec = 0; neww = old;
    if (op < `LW_OP || op > `SB_OP) return;
    if (((op == `LW_OP || op == `SW_OP) && addr % 4 != 0) ||
        ((op == `LH_OP || op == `LHU_OP || op == `SH_OP) && addr % 2 != 0)) begin
      mis = 1; return;
    end
    case (op)
      `LW_OP:  data = old;
      `LH_OP:  data = (h > 32767) ? (h | 32'hFFFF0000) : h;
      `LHU_OP: data = h;
      `LB_OP:  data = (b > 127) ? (b | 32'hFFFFFF00) : b;
      `LBU_OP: data = b;
      default: data = 0;
    endcase
    if (op <= `LBU_OP) lat = RD_LAT + 1;
    else if (op == `SW_OP) begin lat = WR_HOLD + 1; wec = WR_HOLD; neww = wd; end
    else begin
      mask = ((op == `SB_OP) ? 32'hFF : 32'hFFFF) << sh;
      neww = (old & ~mask) | ((wd << sh) & mask);
      lat = RD_LAT + WR_HOLD + 1; wec = WR_HOLD;
    end
  endfunction

  // Drives one request and records what the DUT did up to one cycle after its response.
  task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] data, output logic mis, output int lat, output int wec,
                         output logic [31:0] we_word, output logic [31:0] we_addr,
                         output logic stable, output logic pulse1, output logic held);
    lat = -1; wec = 0; stable = 1; data = 0; mis = 0; we_word = 0; we_addr = 0; pulse1 = 0; held = 0;
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 0; k < 60; k++) begin
      if (mem_we) begin
        if (wec == 0) begin we_word = mem_wdata; we_addr = mem_addr; end
        else if (mem_wdata !== we_word || mem_addr !== we_addr) stable = 0;
        wec++;
      end
      if (resp_valid) begin lat = k; break; end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      data = resp_data; mis = resp_misalign;
      @(posedge clk); #1;
      pulse1 = !resp_valid && !mem_we;
      held = (resp_data === data) && (resp_misalign === mis);
    end
  endtask

  task automatic test_txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got, output logic [31:0] word);
    logic [31:0] ed, ew, wa;
    logic em, m, st, p1, hd;
    int el, ewc, l, wc;
    model(op, addr, wd, ed, em, el, ewc, ew);
    run_req(op, addr, wd, got, m, l, wc, word, wa, st, p1, hd);
    tests++; if (got !== ed) begin fails++; $display("FAIL %s data got %h exp %h", name, got, ed); end
    tests++; if (m !== em) begin fails++; $display("FAIL %s misalign got %0d exp %0d", name, m, em); end
    tests++; if (l !== el) begin fails++; $display("FAIL %s latency got %0d exp %0d", name, l, el); end
    tests++; if (wc !== ewc) begin fails++; $display("FAIL %s we_cycles got %0d exp %0d", name, wc, ewc); end
    tests++; if (!p1 || !hd) begin fails++; $display("FAIL %s pulse/hold got %0d%0d exp 11", name, p1, hd); end
    if (ewc > 0) begin
      tests++; if (word !== ew) begin fails++; $display("FAIL %s mem_wdata got %h exp %h", name, word, ew); end
      tests++; if (wa !== {addr[31:2], 2'b00} || !st) begin
        fails++; $display("FAIL %s mem_addr/stable got %h/%0d exp %h/1", name, wa, st, {addr[31:2], 2'b00});
      end
      ref_mem[addr[9:2]] = ew;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    #12;
    tests++;
    if ({resp_valid, resp_data, resp_misalign, mem_addr, mem_wdata, mem_we, req_ready} !== {1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL reset_state got v%0d d%h m%0d a%h w%h we%0d rdy%0d exp zeros rdy1",
                        resp_valid, resp_data, resp_misalign, mem_addr, mem_wdata, mem_we, req_ready);
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
  endtask

  task automatic test_loads();
    logic [31:0] d, w;
    poke(8'h40, 32'h8899AABB);
    test_txn("lw_100", `LW_OP, 32'h100, 0, d, w);
    tests++; if (d !== 32'h8899AABB) begin fails++; $display("FAIL lw_const got %h exp 8899aabb", d); end
    test_txn("lb_103", `LB_OP, 32'h103, 0, d, w);
    tests++; if (d !== 32'hFFFFFF88) begin fails++; $display("FAIL lb_const got %h exp ffffff88", d); end
    test_txn("lbu_103", `LBU_OP, 32'h103, 0, d, w);
    tests++; if (d !== 32'h00000088) begin fails++; $display("FAIL lbu_const got %h exp 00000088", d); end
    test_txn("lh_102", `LH_OP, 32'h102, 0, d, w);
    tests++; if (d !== 32'hFFFF8899) begin fails++; $display("FAIL lh_const got %h exp ffff8899", d); end
    test_txn("lhu_100", `LHU_OP, 32'h100, 0, d, w);
    tests++; if (d !== 32'h0000AABB) begin fails++; $display("FAIL lhu_const got %h exp 0000aabb", d); end
  endtask

  task automatic test_stores();
    logic [31:0] d, w;
    test_txn("sb_101", `SB_OP, 32'h101, 32'h12345677, d, w);
    tests++; if (w !== 32'h889977BB) begin fails++; $display("FAIL sb_merge_const got %h exp 889977bb", w); end
    test_txn("lw_after_sb", `LW_OP, 32'h100, 0, d, w);
    test_txn("sw_104", `SW_OP, 32'h104, 32'hDEADBEEF, d, w);
    test_txn("lw_after_sw", `LW_OP, 32'h104, 0, d, w);
    tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_readback got %h exp deadbeef", d); end
    test_txn("sh_106", `SH_OP, 32'h106, 32'h0000CAFE, d, w);
  endtask

  task automatic test_misalign();
    logic [31:0] d, w;
    test_txn("lw_102_mis", `LW_OP, 32'h102, 0, d, w);
    test_txn("sh_101_mis", `SH_OP, 32'h101, 32'h1234, d, w);
    test_txn("sw_103_mis", `SW_OP, 32'h103, 32'h1234, d, w);
    test_txn("unknown_op0", 4'd0, 32'h100, 0, d, w);
    test_txn("unknown_op15", 4'd15, 32'h100, 0, d, w);
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    req_valid = 1; req_op = `LW_OP; req_addr = 32'h100; req_wdata = 0;
    @(posedge clk); #1;
    req_addr = 32'h104;
    for (k = 0; k < 20 && !resp_valid; k++) begin @(posedge clk); #1; end
    tests++;
    if (!resp_valid || !req_ready || resp_data !== ref_mem[8'h40]) begin
      fails++; $display("FAIL b2b_first got v%0d rdy%0d d%h exp 1 1 %h", resp_valid, req_ready, resp_data, ref_mem[8'h40]);
    end
    @(posedge clk); #1;
    req_valid = 0;
    tests++;
    if (resp_valid || req_ready) begin
      fails++; $display("FAIL b2b_accept got v%0d rdy%0d exp v0 rdy0", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (!resp_valid || resp_data !== ref_mem[8'h41]) begin
      fails++; $display("FAIL b2b_second got v%0d d%h exp v1 d%h", resp_valid, resp_data, ref_mem[8'h41]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d, w;
    logic saw;
    @(negedge clk);
    req_valid = 1; req_op = `SW_OP; req_addr = 32'h200; req_wdata = 32'h5A5A1234;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #2;
    rst_n = 0; #1;
    tests++;
    if (mem_we || !req_ready || resp_valid) begin
      fails++; $display("FAIL rst_mid_wr got we%0d rdy%0d v%0d exp we0 rdy1 v0", mem_we, req_ready, resp_valid);
    end
    @(negedge clk); @(negedge clk); rst_n = 1;
    saw = 0;
    repeat (8) begin @(posedge clk); #1; if (resp_valid || mem_we) saw = 1; end
    tests++; if (saw) begin fails++; $display("FAIL rst_no_resp got activity 1 exp 0"); end
    tests++; if (mem[8'h80] !== ref_mem[8'h80]) begin
      fails++; $display("FAIL rst_abandon got %h exp %h", mem[8'h80], ref_mem[8'h80]);
    end
    test_txn("lw_after_rst", `LW_OP, 32'h300, 0, d, w);
  endtask

  task automatic test_random();
    logic [31:0] d, w, a;
    logic [3:0] op;
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 9) ? ((($urandom_range(0, 1)) == 0) ? 4'd0 : 4'($urandom_range(9, 15))) : 4'(r == 0 ? 1 : r);
      a = 32'($urandom_range(0, 1023));
      test_txn($sformatf("rand%0d_op%0d", i, op), op, a, $urandom, d, w);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side initiator for the data port of the unified memory.
- Accepts one load/store request at a time from the MEM pipeline stage and drives word-aligned address, write data and write enable to the memory's port b.
- Performs byte/half extraction and sign/zero extension for loads, and read-modify-write merging for SB/SH.
- Holds write enable for the memory's full write-commit window, flags misaligned accesses, and returns a single-cycle response pulse.

Parameters:
- RD_LAT, 1, cycles from driving mem_addr to valid mem_rdata (memory read latency).
- WR_HOLD, 4, cycles mem_we is held high per write; covers the memory's 4-phase commit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  `LDST_WID  `LW_OP/`LH_OP/`LHU_OP/`LB_OP/`LBU_OP/`SW_OP/`SH_OP/`SB_OP.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result, extended; 0 for stores and errors.
- resp_misalign  out  1  valid with resp_valid; access was misaligned.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  raw word from memory.

Behaviour:
- Reset (rst low, async): state IDLE, all registered outputs 0 (resp_valid, resp_data, resp_misalign, mem_addr, mem_wdata, mem_we); req_ready=1.
- Reset mid-operation: mem_we drops immediately and the write is abandoned. No response is produced.
- FSM states: IDLE, RD, WR, RESP.
- Acceptance: in IDLE, on a clock edge with req_valid=1, latch op/addr/wdata and drive mem_addr at the same edge.
- Transitions from IDLE:
  - misaligned (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0) -> RESP with resp_misalign=1, resp_data=0, no memory access.
  - unrecognized op -> RESP with resp_misalign=0, resp_data=0, no memory access.
  - loads, SH, SB -> RD.
  - SW -> WR with mem_wdata=req_wdata and mem_we=1.
- RD: stays RD_LAT cycles (down-counter). On the final edge, mem_rdata is captured.
  - Loads: go to RESP with resp_data extracted.
  - SH/SB: merged word goes to mem_wdata; set mem_we=1; go to WR.
- Load extraction (byte lane = addr[1:0]):
  - LW: whole word.
  - LH/LHU: half [31:16] if addr[1], else [15:0]; sign- or zero-extended.
  - LB/LBU: byte [8*addr[1:0]+7 : 8*addr[1:0]]; sign- or zero-extended.
- Merge: only the addressed byte/half lane is replaced with req_wdata[7:0]/[15:0]; all other bits come from mem_rdata.
- WR: mem_we held high exactly WR_HOLD consecutive cycles, with mem_addr and mem_wdata stable throughout. Then mem_we=0 and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The consumer has no backpressure and must take it.
- resp_data and resp_misalign hold their values until the next response. resp_data is 0 for stores.
- req_ready = (state==IDLE). req_valid outside IDLE is ignored; the request must be held by the requester.
- Latency, measured from the accepting edge to the first cycle of resp_valid:
  - loads: RD_LAT+1 cycles;
  - SW: WR_HOLD+1;
  - SH/SB: RD_LAT+WR_HOLD+1;
  - misaligned/unknown: 1.
- Back-to-back: a new request may be accepted on the edge that leaves RESP->IDLE+1, i.e. minimum one idle cycle between responses.
- mem_we is never high outside WR.

Test Plan:
- Reset, then LW addr 0x100, memory word 0x8899AABB -> resp_valid 2 cycles after accept, resp_data=0x8899AABB, resp_misalign=0, mem_we never high.
- LB addr 0x103 on word 0x8899AABB -> resp_data=0xFFFFFF88. LBU same addr -> 0x00000088. LH addr 0x102 -> 0xFFFF8899. LHU addr 0x100 -> 0x0000AABB.
- SB addr 0x101 wdata 0x12345677, old word 0x8899AABB -> mem_wdata=0x889977BB, mem_we high exactly 4 cycles, then resp_valid with resp_data=0.
- SW addr 0x104 wdata 0xDEADBEEF -> mem_we 4 cycles with mem_addr=0x104, resp_valid 5 cycles after accept.
- LW addr 0x102 and SH addr 0x101 -> resp_misalign=1 one cycle after accept, resp_data=0, mem_we stays 0.
- Assert rst low during the 2nd WR cycle of an SW -> mem_we=0 immediately, no resp_valid, req_ready=1. After release, an LW completes normally.
